// File: rtl/updown_counter_bank.sv
// updown_counter_bank
// Bank of independent up/down counters. Each channel counts modulo LIMIT+1 and
// either wraps or saturates at the bounds. Each channel has a synchronous load,
// terminal flags and a registered one-cycle boundary event. The bank also holds
// a shared free-running cycle counter.
module updown_counter_bank #(
    parameter int                 WIDTH    = 32,
    parameter int                 CHANNELS = 4,
    parameter logic [WIDTH-1:0]   LIMIT    = {WIDTH{1'b1}},
    parameter bit                 SATURATE = 1'b0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        en,
    input  logic [CHANNELS-1:0]        dir,
    input  logic [CHANNELS-1:0]        load,
    input  logic [CHANNELS*WIDTH-1:0]  load_value,
    output logic [CHANNELS*WIDTH-1:0]  value,
    output logic [CHANNELS-1:0]        at_max,
    output logic [CHANNELS-1:0]        at_min,
    output logic [CHANNELS-1:0]        wrap,
    output logic [WIDTH-1:0]           cycle_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cycle_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] value_reg;
            logic [WIDTH-1:0] value_next;
            logic             wrap_reg;
            logic             wrap_next;
            logic [WIDTH-1:0] chan_load_value;

            assign chan_load_value = load_value[gi*WIDTH +: WIDTH];

            // Next-state decode: load beats counting; boundary steps flag an event.
            always_comb begin
                value_next = value_reg;
                wrap_next  = 1'b0;
                if (load[gi]) begin
                    // Loads above the terminal value are clipped to it.
                    value_next = (chan_load_value > LIMIT) ? LIMIT : chan_load_value;
                end else if (en[gi]) begin
                    if (dir[gi]) begin
                        if (value_reg == LIMIT) begin
                            wrap_next  = 1'b1;
                            value_next = SATURATE ? LIMIT : '0;
                        end else begin
                            value_next = value_reg + ONE;
                        end
                    end else begin
                        if (value_reg == '0) begin
                            wrap_next  = 1'b1;
                            value_next = SATURATE ? '0 : LIMIT;
                        end else begin
                            value_next = value_reg - ONE;
                        end
                    end
                end
            end

            // Channel state registers with synchronous reset.
            always_ff @(posedge clock) begin
                if (reset) begin
                    value_reg <= '0;
                    wrap_reg  <= 1'b0;
                end else begin
                    value_reg <= value_next;
                    wrap_reg  <= wrap_next;
                end
            end

            assign value[gi*WIDTH +: WIDTH] = value_reg;
            assign wrap[gi]   = wrap_reg;
            assign at_max[gi] = (value_reg == LIMIT);
            assign at_min[gi] = (value_reg == '0);
        end
    endgenerate

    // Free-running edge counter; wraps naturally at 2**WIDTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count_reg <= '0;
        end else begin
            cycle_count_reg <= cycle_count_reg + ONE;
        end
    end

    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_updown_counter_bank.sv
// Testbench for updown_counter_bank: a table of directed vectors on a wrap-mode
// WIDTH=4/LIMIT=9 instance, plus hand-written sequences on a saturate-mode
// instance and a WIDTH=8 instance for reset-mid-operation.
module tb_updown_counter_bank;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- wrap-mode instance (WIDTH=4, CHANNELS=2, LIMIT=9)
    logic       w_reset = 1'b1;
    logic [1:0] w_en = '0, w_dir = '0, w_load = '0;
    logic [7:0] w_load_value = '0;
    logic [7:0] w_value;
    logic [1:0] w_at_max, w_at_min, w_wrap;
    logic [3:0] w_cycle_count;

    updown_counter_bank #(.WIDTH(4), .CHANNELS(2), .LIMIT(4'd9), .SATURATE(1'b0)) dut_w (
        .clock(clock), .reset(w_reset), .en(w_en), .dir(w_dir), .load(w_load),
        .load_value(w_load_value), .value(w_value), .at_max(w_at_max),
        .at_min(w_at_min), .wrap(w_wrap), .cycle_count(w_cycle_count)
    );

    // ---------------- saturate-mode instance
    logic       s_reset = 1'b1;
    logic [1:0] s_en = '0, s_dir = '0, s_load = '0;
    logic [7:0] s_load_value = '0;
    logic [7:0] s_value;
    logic [1:0] s_at_max, s_at_min, s_wrap;
    logic [3:0] s_cycle_count;

    updown_counter_bank #(.WIDTH(4), .CHANNELS(2), .LIMIT(4'd9), .SATURATE(1'b1)) dut_s (
        .clock(clock), .reset(s_reset), .en(s_en), .dir(s_dir), .load(s_load),
        .load_value(s_load_value), .value(s_value), .at_max(s_at_max),
        .at_min(s_at_min), .wrap(s_wrap), .cycle_count(s_cycle_count)
    );

    // ---------------- WIDTH=8 instance
    logic        e_reset = 1'b1;
    logic [1:0]  e_en = '0, e_dir = '0, e_load = '0;
    logic [15:0] e_load_value = '0;
    logic [15:0] e_value;
    logic [1:0]  e_at_max, e_at_min, e_wrap;
    logic [7:0]  e_cycle_count;

    updown_counter_bank #(.WIDTH(8), .CHANNELS(2), .LIMIT(8'd9), .SATURATE(1'b0)) dut_e (
        .clock(clock), .reset(e_reset), .en(e_en), .dir(e_dir), .load(e_load),
        .load_value(e_load_value), .value(e_value), .at_max(e_at_max),
        .at_min(e_at_min), .wrap(e_wrap), .cycle_count(e_cycle_count)
    );

    typedef struct {
        logic       rst;
        logic [1:0] en;
        logic [1:0] dir;
        logic [1:0] load;
        logic [7:0] lv;
        logic [3:0] v0;
        logic [3:0] v1;
        logic [1:0] wr;
        logic [3:0] cc;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rst, input logic [1:0] en, input logic [1:0] dir,
                           input logic [1:0] load, input logic [7:0] lv,
                           input logic [3:0] v0, input logic [3:0] v1,
                           input logic [1:0] wr, input logic [3:0] cc);
        vec_t v;
        v.rst = rst; v.en = en; v.dir = dir; v.load = load; v.lv = lv;
        v.v0 = v0; v.v1 = v1; v.wr = wr; v.cc = cc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Build the vector table for the wrap-mode instance.
        add_vec(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 4'd0, 4'd0, 2'b00, 4'd0);
        for (int k = 1; k <= 12; k++)
            add_vec(1'b0, 2'b01, 2'b01, 2'b00, 8'h00, 4'(k % 10), 4'd0,
                    (k == 10) ? 2'b01 : 2'b00, 4'(k));
        add_vec(1'b0, 2'b00, 2'b00, 2'b01, 8'h00, 4'd0, 4'd0, 2'b00, 4'd13); // load 0
        add_vec(1'b0, 2'b01, 2'b00, 2'b00, 8'h00, 4'd9, 4'd0, 2'b01, 4'd14); // down from 0
        add_vec(1'b0, 2'b01, 2'b00, 2'b00, 8'h00, 4'd8, 4'd0, 2'b00, 4'd15);
        add_vec(1'b0, 2'b10, 2'b10, 2'b10, 8'hD0, 4'd8, 4'd9, 2'b00, 4'd0);  // clip 13->9, cc wraps
        add_vec(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 4'd8, 4'd0, 2'b10, 4'd1);
        add_vec(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 4'd8, 4'd0, 2'b00, 4'd2);  // hold, wrap clears
        add_vec(1'b0, 2'b01, 2'b00, 2'b00, 8'h00, 4'd7, 4'd0, 2'b00, 4'd3);  // direction toggles
        add_vec(1'b0, 2'b01, 2'b01, 2'b00, 8'h00, 4'd8, 4'd0, 2'b00, 4'd4);
        add_vec(1'b1, 2'b11, 2'b11, 2'b01, 8'h05, 4'd0, 4'd0, 2'b00, 4'd0);  // reset wins
        add_vec(1'b0, 2'b01, 2'b01, 2'b00, 8'h00, 4'd1, 4'd0, 2'b00, 4'd1);

        // Apply table-driven vectors.
        foreach (vecs[i]) begin
            logic [3:0] g0, g1;
            logic [1:0] emax, emin;
            w_reset = vecs[i].rst; w_en = vecs[i].en; w_dir = vecs[i].dir;
            w_load = vecs[i].load; w_load_value = vecs[i].lv;
            tick();
            g0 = w_value[3:0];
            g1 = w_value[7:4];
            emax = {vecs[i].v1 == 4'd9, vecs[i].v0 == 4'd9};
            emin = {vecs[i].v1 == 4'd0, vecs[i].v0 == 4'd0};
            $display("vec %0d: v0=%0d v1=%0d wrap=%b max=%b min=%b cc=%0d", i, g0, g1,
                     w_wrap, w_at_max, w_at_min, w_cycle_count);
            check($sformatf("vec%0d_v0", i), 32'(g0), 32'(vecs[i].v0));
            check($sformatf("vec%0d_v1", i), 32'(g1), 32'(vecs[i].v1));
            check($sformatf("vec%0d_wrap", i), 32'(w_wrap), 32'(vecs[i].wr));
            check($sformatf("vec%0d_at_max", i), 32'(w_at_max), 32'(emax));
            check($sformatf("vec%0d_at_min", i), 32'(w_at_min), 32'(emin));
            check($sformatf("vec%0d_cc", i), 32'(w_cycle_count), 32'(vecs[i].cc));
        end

        // Saturate mode: load 7, count up into the bound, then down at 0.
        s_reset = 1'b1; tick();
        check("sat_reset_value", 32'(s_value), 32'h0);
        check("sat_reset_min", 32'(s_at_min), 32'h3);
        s_reset = 1'b0; s_load = 2'b01; s_load_value = 8'h07; tick();
        $display("sat load: v0=%0d wrap=%b", s_value[3:0], s_wrap);
        check("sat_load7", 32'(s_value[3:0]), 32'd7);
        s_load = 2'b00; s_en = 2'b01; s_dir = 2'b01;
        begin
            logic [3:0] exp_v[4] = '{4'd8, 4'd9, 4'd9, 4'd9};
            logic       exp_w[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
            for (int k = 0; k < 4; k++) begin
                tick();
                $display("sat up %0d: v0=%0d wrap=%b max=%b", k, s_value[3:0], s_wrap, s_at_max);
                check($sformatf("sat_up%0d_v", k), 32'(s_value[3:0]), 32'(exp_v[k]));
                check($sformatf("sat_up%0d_wrap", k), 32'(s_wrap[0]), 32'(exp_w[k]));
            end
        end
        check("sat_at_max", 32'(s_at_max), 32'h1);
        s_en = 2'b00; s_load = 2'b01; s_load_value = 8'h00; tick();
        check("sat_load0_wrap", 32'(s_wrap), 32'h0);
        s_load = 2'b00; s_en = 2'b01; s_dir = 2'b00;
        for (int k = 0; k < 2; k++) begin
            tick();
            $display("sat down %0d: v0=%0d wrap=%b", k, s_value[3:0], s_wrap);
            check($sformatf("sat_dn%0d_v", k), 32'(s_value[3:0]), 32'd0);
            check($sformatf("sat_dn%0d_wrap", k), 32'(s_wrap[0]), 32'd1);
        end
        s_en = 2'b00; tick();
        check("sat_idle_wrap", 32'(s_wrap), 32'h0);

        // WIDTH=8: reach ch0=5, ch1=3, cycle_count=20, then reset mid-operation.
        e_reset = 1'b1; tick();
        e_reset = 1'b0; e_load = 2'b11; e_load_value = {8'd3, 8'd5}; tick();
        e_load = 2'b00;
        for (int k = 0; k < 19; k++) tick();
        $display("w8 pre-reset: v0=%0d v1=%0d cc=%0d", e_value[7:0], e_value[15:8], e_cycle_count);
        check("w8_pre_v0", 32'(e_value[7:0]), 32'd5);
        check("w8_pre_v1", 32'(e_value[15:8]), 32'd3);
        check("w8_pre_cc", 32'(e_cycle_count), 32'd20);
        e_reset = 1'b1; e_load = 2'b01; e_load_value = 16'h0007; e_en = 2'b11; e_dir = 2'b11; tick();
        $display("w8 reset: value=%0h wrap=%b min=%b max=%b cc=%0d", e_value, e_wrap,
                 e_at_min, e_at_max, e_cycle_count);
        check("w8_rst_value", 32'(e_value), 32'h0);
        check("w8_rst_wrap", 32'(e_wrap), 32'h0);
        check("w8_rst_min", 32'(e_at_min), 32'h3);
        check("w8_rst_max", 32'(e_at_max), 32'h0);
        check("w8_rst_cc", 32'(e_cycle_count), 32'h0);
        e_reset = 1'b0; e_load = 2'b00; e_en = 2'b01; e_dir = 2'b01; tick();
        $display("w8 post-reset: v0=%0d cc=%0d", e_value[7:0], e_cycle_count);
        check("w8_post_v0", 32'(e_value[7:0]), 32'd1);
        check("w8_post_cc", 32'(e_cycle_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
